mem_block_copier: RTL

- Memory-side initiator that drives the team's single-port synchronous memory (imem/dmem model) to perform block copy and block fill, without pipeline involvement.
- Sits between the control/CSR logic and the data-memory port; the copier is bus master for the whole operation.
- The memory port has 1-cycle read latency: address is registered at posedge and read data is valid the following cycle. Writes commit at posedge when wen=1.

---
 rtl/mem_block_copier_pkg.sv | 27 ++
 rtl/mem_block_copier_if.sv | 32 +++
 rtl/mem_block_copier_addr_gen.sv | 70 +++++++
 rtl/mem_block_copier.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_block_copier_pkg.sv
// Shared widths, FSM state encoding and mode codes for the block copier.
package mem_block_copier_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Destination lies above the source inside the copied window: ascending order would
    // overwrite source words before they are read.
    function automatic logic dst_overlaps_above(input logic [ISIZE-1:0] src,
                                                input logic [ISIZE-1:0] dst,
                                                input logic [ISIZE-1:0] len);
        logic [ISIZE-1:0] diff;
        diff = dst - src;
        return (diff != '0) && (diff < len);
    endfunction

endpackage

// File: rtl/mem_block_copier_if.sv
// Control-side request/status and memory-port signals of the block copier.
interface mem_block_copier_if;
    import mem_block_copier_pkg::*;

    // start is a single-cycle strobe, honoured only while idle and never queued;
    // done pulses for exactly one cycle when an operation (including len=0) completes.
    logic             start;
    logic             mode;
    logic [ISIZE-1:0] src_addr;
    logic [ISIZE-1:0] dst_addr;
    logic [ISIZE-1:0] len;
    logic [DSIZE-1:0] fill_data;
    logic             busy;
    logic             done;
    logic [DSIZE-1:0] csum;
    logic             mem_wen;
    logic [ISIZE-1:0] mem_addr;
    logic [DSIZE-1:0] mem_wdata;
    logic [DSIZE-1:0] mem_rdata;
    state_t           dbg_state;

    modport master (
        input  start, mode, src_addr, dst_addr, len, fill_data, mem_rdata,
        output busy, done, csum, mem_wen, mem_addr, mem_wdata, dbg_state
    );

    modport slave (
        output start, mode, src_addr, dst_addr, len, fill_data, mem_rdata,
        input  busy, done, csum, mem_wen, mem_addr, mem_wdata, dbg_state
    );

endinterface

// File: rtl/mem_block_copier_addr_gen.sv
// Source/destination pointers and remaining-word count; picks traversal direction at load.
module mem_block_copier_addr_gen
    import mem_block_copier_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_mode,
    input  logic [ISIZE-1:0] i_src,
    input  logic [ISIZE-1:0] i_dst,
    input  logic [ISIZE-1:0] i_len,
    input  logic             i_step,
    output logic [ISIZE-1:0] o_src_nxt,
    output logic [ISIZE-1:0] o_dst_nxt,
    output logic             o_last
);

    logic [ISIZE-1:0] r_src_ptr;
    logic [ISIZE-1:0] r_dst_ptr;
    logic [ISIZE-1:0] r_remain;
    logic             r_desc;

    logic             w_overlap;
    logic [ISIZE-1:0] w_src_init;
    logic [ISIZE-1:0] w_dst_init;
    logic [ISIZE-1:0] w_inc;
    logic [ISIZE-1:0] w_src_step;
    logic [ISIZE-1:0] w_dst_step;

    assign w_overlap  = (i_mode == MODE_COPY) && dst_overlaps_above(i_src, i_dst, i_len);
    assign w_src_init = w_overlap ? (i_src + i_len - ISIZE'(1)) : i_src;
    assign w_dst_init = w_overlap ? (i_dst + i_len - ISIZE'(1)) : i_dst;
    // All-ones added modulo 2^ISIZE is a decrement.
    assign w_inc      = r_desc ? '1 : ISIZE'(1);
    assign w_src_step = r_src_ptr + w_inc;
    assign w_dst_step = r_dst_ptr + w_inc;
    assign o_last     = (r_remain == ISIZE'(1));

    // Pointer values after the coming edge, so the top can register mem_addr in step.
    always_comb begin
        o_src_nxt = r_src_ptr;
        o_dst_nxt = r_dst_ptr;
        if (i_load) begin
            o_src_nxt = w_src_init;
            o_dst_nxt = w_dst_init;
        end else if (i_step) begin
            o_src_nxt = w_src_step;
            o_dst_nxt = w_dst_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_remain  <= '0;
            r_desc    <= 1'b0;
        end else if (i_load) begin
            r_src_ptr <= w_src_init;
            r_dst_ptr <= w_dst_init;
            r_remain  <= i_len;
            r_desc    <= w_overlap;
        end else if (i_step) begin
            r_src_ptr <= w_src_step;
            r_dst_ptr <= w_dst_step;
            r_remain  <= r_remain - ISIZE'(1);
        end
    end

endmodule

// File: rtl/mem_block_copier.sv
// Block copy / block fill initiator driving a single-port memory with 1-cycle read latency.
module mem_block_copier
    import mem_block_copier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mem_block_copier_if.master   bus
);

    state_t           r_state;
    logic             r_mode;
    logic [DSIZE-1:0] r_fill;
    logic             r_busy;
    logic             r_done;
    logic             r_wen;
    logic [ISIZE-1:0] r_addr;
    logic [DSIZE-1:0] r_csum;

    logic             w_load;
    logic             w_step;
    logic [ISIZE-1:0] w_src_nxt;
    logic [ISIZE-1:0] w_dst_nxt;
    logic             w_last;
    logic [DSIZE-1:0] w_wdata;

    assign w_load = (r_state == ST_IDLE) && bus.start;
    assign w_step = (r_state == ST_WR);

    mem_block_copier_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_mode    (bus.mode),
        .i_src     (bus.src_addr),
        .i_dst     (bus.dst_addr),
        .i_len     (bus.len),
        .i_step    (w_step),
        .o_src_nxt (w_src_nxt),
        .o_dst_nxt (w_dst_nxt),
        .o_last    (w_last)
    );

    // Read data arrives in the WR cycle itself, so the write data path cannot be registered.
    assign w_wdata = (r_state != ST_WR)     ? '0     :
                     (r_mode == MODE_FILL)  ? r_fill : bus.mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_COPY;
            r_fill  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_csum  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_fill <= bus.fill_data;
                        r_csum <= '0;
                        if (bus.len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else if (bus.mode == MODE_COPY) begin
                            r_state <= ST_RD;
                            r_busy  <= 1'b1;
                            r_addr  <= w_src_nxt;
                        end else begin
                            r_state <= ST_WR;
                            r_busy  <= 1'b1;
                            r_wen   <= 1'b1;
                            r_addr  <= w_dst_nxt;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_WR;
                    r_wen   <= 1'b1;
                    r_addr  <= w_dst_nxt;
                end
                ST_WR: begin
                    r_csum <= r_csum ^ w_wdata;
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_wen   <= 1'b0;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else if (r_mode == MODE_COPY) begin
                        r_state <= ST_RD;
                        r_wen   <= 1'b0;
                        r_addr  <= w_src_nxt;
                    end else begin
                        r_addr  <= w_dst_nxt;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.csum      = r_csum;
    assign bus.mem_wen   = r_wen;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.dbg_state = r_state;

endmodule
